// File: rtl/radix4_mux_multiplier.sv
// Sequential unsigned multiplier retiring two multiplier bits per clock.
// Each step a 2-bit digit selects 0, A, 2A or 3A into a double-width accumulator.
module radix4_mux_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Ready,
    output logic               Busy,
    output logic [1:0]         Selection,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);

    localparam int STEPS = WIDTH / 2;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW    = WIDTH + 2;
    localparam int AW    = 2 * WIDTH;
    localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] shreg;
    logic [SW-1:0]    step;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_next;
    logic [AW-1:0]    pp_wide;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    a_x1;
    logic [PW-1:0]    a_x2;
    logic [PW-1:0]    a_x3;
    logic [SW:0]      shamt;

    assign a_x1 = {2'b00, mcand};
    assign a_x2 = {1'b0, mcand, 1'b0};
    assign a_x3 = a_x1 + a_x2;

    // Four-way partial-product mux driven by the current multiplier digit
    always_comb begin
        pp = '0;
        unique case (shreg[1:0])
            2'b00: pp = '0;
            2'b01: pp = a_x1;
            2'b10: pp = a_x2;
            2'b11: pp = a_x3;
        endcase
    end

    assign shamt    = {step, 1'b0};
    assign pp_wide  = {{(AW-PW){1'b0}}, pp} << shamt;
    assign acc_next = acc + pp_wide;

    assign Ready     = (state == IDLE);
    assign Busy      = (state == RUN) || (state == DONE);
    assign Done      = (state == DONE);
    assign Selection = (state == RUN) ? shreg[1:0] : 2'b00;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            mcand   <= '0;
            shreg   <= '0;
            step    <= '0;
            acc     <= '0;
            Product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        mcand <= A;
                        shreg <= B;
                        acc   <= '0;
                        step  <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    shreg <= shreg >> 2;
                    step  <= step + 1'b1;
                    if (step == LAST) begin
                        Product <= acc_next;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix4_mux_multiplier.sv
// Self-checking bench for radix4_mux_multiplier (WIDTH=16).
// Directed scenarios followed by random operands against an A*B model.
module tb_radix4_mux_multiplier;

    localparam int W = 16;

    logic           Clock = 1'b0;
    logic           Reset;
    logic           Start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           Ready;
    logic           Busy;
    logic [1:0]     Selection;
    logic           Done;
    logic [2*W-1:0] Product;

    int n_assert = 0;
    int n_fail   = 0;
    logic [2*W-1:0] prev_prod;

    radix4_mux_multiplier #(.WIDTH(W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .Ready     (Ready),
        .Busy      (Busy),
        .Selection (Selection),
        .Done      (Done),
        .Product   (Product)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller sits at a negedge with Ready=1. Returns at the negedge after Done.
    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit chk_seq);
        int lat;
        logic [2*W-1:0] exp;
        logic [W-1:0] bd;
        exp = 32'(a) * 32'(b);
        chk({tag, "_ready_pre"}, 64'(Ready), 64'd1);
        A = a;
        B = b;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        if (chk_seq) chk({tag, "_ready_fall"}, 64'(Ready), 64'd0);
        lat = 0;
        while (!Done && lat < 20) begin
            if (chk_seq) begin
                bd = b >> (2 * lat);
                chk({tag, "_sel"}, 64'(Selection), 64'(bd[1:0]));
                chk({tag, "_busy"}, 64'(Busy), 64'd1);
            end
            chk({tag, "_held"}, 64'(Product), 64'(prev_prod));
            @(negedge Clock);
            lat++;
        end
        chk({tag, "_done_seen"}, 64'(Done), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'd8);
        chk({tag, "_product"}, 64'(Product), 64'(exp));
        prev_prod = exp;
        @(negedge Clock);
        chk({tag, "_done_width"}, 64'(Done), 64'd0);
        chk({tag, "_ready_back"}, 64'(Ready), 64'd1);
        chk({tag, "_product_hold"}, 64'(Product), 64'(exp));
    endtask

    initial begin
        int t_acc1;
        int t_acc2;
        int cyc;
        int lat;
        Reset = 1'b1;
        Start = 1'b1;
        A = 16'h1111;
        B = 16'h2222;
        prev_prod = '0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0;
        chk("rst_ready", 64'(Ready), 64'd1);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_sel", 64'(Selection), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_product", 64'(Product), 64'd0);
        @(negedge Clock);
        chk("rst_idle_hold", 64'(Ready), 64'd1);

        // 1, 2, 3: directed products with selection sequences
        run_op("t1", 16'd3, 16'd5, 1'b1);
        run_op("t2", 16'hFFFF, 16'hFFFF, 1'b1);
        chk("t2_const", 64'(Product), 64'hFFFE0001);
        run_op("t3a", 16'h0000, 16'h1234, 1'b1);
        run_op("t3b", 16'hABCD, 16'h0000, 1'b1);

        // 4: Start held high across back-to-back operations
        cyc = 0;
        A = 16'd7;
        B = 16'd9;
        Start = 1'b1;
        @(negedge Clock);
        cyc++;
        t_acc1 = cyc;
        A = 16'd100;
        B = 16'd200;
        chk("t4_ready_fall", 64'(Ready), 64'd0);
        lat = 0;
        while (!Done && lat < 20) begin
            @(negedge Clock);
            cyc++;
            lat++;
        end
        chk("t4_lat1", 64'(lat), 64'd8);
        chk("t4_prod1", 64'(Product), 64'd63);
        @(negedge Clock);
        cyc++;
        chk("t4_ready_gap", 64'(Ready), 64'd1);
        @(negedge Clock);
        cyc++;
        t_acc2 = cyc;
        A = 16'd5;
        B = 16'd5;
        chk("t4_spacing", 64'(t_acc2 - t_acc1), 64'd10);
        chk("t4_busy2", 64'(Busy), 64'd1);
        lat = 0;
        while (!Done && lat < 20) begin
            @(negedge Clock);
            lat++;
        end
        chk("t4_lat2", 64'(lat), 64'd8);
        chk("t4_prod2", 64'(Product), 64'd20000);
        @(negedge Clock);
        Start = 1'b0;
        chk("t4_ready_end", 64'(Ready), 64'd1);
        @(negedge Clock);
        chk("t4_no_accept", 64'(Ready), 64'd1);
        prev_prod = 32'd20000;

        // 5: Reset with Start mid-RUN
        A = 16'h1357;
        B = 16'h2468;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        chk("t5_busy_pre", 64'(Busy), 64'd1);
        Reset = 1'b1;
        Start = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0;
        chk("t5_ready", 64'(Ready), 64'd1);
        chk("t5_busy", 64'(Busy), 64'd0);
        chk("t5_product", 64'(Product), 64'd0);
        chk("t5_done", 64'(Done), 64'd0);
        chk("t5_sel", 64'(Selection), 64'd0);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            if (Done || !Ready) lat++;
        end
        chk("t5_quiet", 64'(lat), 64'd0);
        prev_prod = '0;
        run_op("t5_fresh", 16'd12, 16'd12, 1'b1);
        chk("t5_144", 64'(Product), 64'd144);

        // 6: random operands against the A*B model
        for (int i = 0; i < 1000; i++) begin
            run_op("rnd", W'($urandom), W'($urandom), (i % 50) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/radix4_mux_multiplier.md
# radix4_mux_multiplier

- Sequential unsigned multiplier. It retires two multiplier bits per clock.
- Each step, the 2-bit multiplier digit selects one of four pre-formed partial products: 0, A, 2A or 3A. This is the four-way selection used by the array-multiplier datapath.
- The selected partial product is accumulated into a double-width product.
- The block sits upstream of the result/display logic. It accepts one operand pair per Start/Ready handshake and emits a one-cycle Done pulse with a held Product.

## Interface

Parameters:
- WIDTH, default 16: operand width. It must be even and at least 4.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high; clock Clock
- Start  in  1  request to multiply; sampled only while Ready=1
- A  in  WIDTH  multiplicand, captured on the accepting edge
- B  in  WIDTH  multiplier, captured on the accepting edge
- Ready  out  1  high in IDLE; Start is accepted only when Ready=1
- Busy  out  1  high in RUN and DONE
- Selection  out  2  current multiplier digit (mux select); 2'b00 outside RUN
- Done  out  1  one-cycle pulse; Product is valid from this cycle on
- Product  out  2*WIDTH  A*B, held until the next accepted Start completes

## Operation

States: IDLE, RUN, DONE. Encoding is free. The state register is the only source of Ready, Busy and Selection.

IDLE:
- Ready=1, Busy=0, Done=0.
- On an edge with Start=1, capture A into the multiplicand register and B into the shift register.
- On the same edge, clear the accumulator and step counter, then go to RUN.

RUN:
- Selection = the shift register bits [1:0].
- The partial product is WIDTH+2 bits. Select it as follows: 00 gives 0, 01 gives A, 10 gives A<<1, 11 gives A+(A<<1).
- Each edge does three things:
  - acc <= acc + (pp << 2*step), truncated to 2*WIDTH bits. No overflow is possible for unsigned operands.
  - The shift register shifts right by 2.
  - step <= step+1.
- On the edge where step == WIDTH/2-1, the final sum is written to both acc and Product, and the state goes to DONE.

DONE:
- Done=1 and Busy=1 for exactly one cycle.
- The next edge returns to IDLE unconditionally.

Other rules:
- Start while Ready=0 is ignored. It is not queued and does not disturb the operation in progress.
- A and B may change freely after the accepting edge.
- Product changes only on the RUN→DONE edge and on Reset. Between those events it holds its value, including through IDLE and any later RUN.
- Reset, at any edge and in any state (including mid-RUN and in DONE):
  - state goes to IDLE; acc, step and the shift register go to 0;
  - Product=0, Done=0.
  - A Start on the same edge as Reset is ignored.
- Values after reset: Ready=1, Busy=0, Selection=00, Done=0, Product=0.

## Timing

- Accepting edge is t0. RUN covers the edges t0+1 … t0+WIDTH/2.
- Done=1 and Product valid in the cycle after edge t0+WIDTH/2. Latency is WIDTH/2 clocks; 8 for WIDTH=16.
- DONE→IDLE at edge t0+WIDTH/2+1. The earliest next accept is edge t0+WIDTH/2+2, so sustained throughput is one product per WIDTH/2+2 clocks (10 for WIDTH=16).
- Selection during the cycle before RUN edge t0+k (k=1..WIDTH/2) equals B[2k-1:2k-2] of the captured B.
- No combinational path from Start, A or B to any output.

## Test plan

1. WIDTH=16. Start with A=3, B=5. Required: Ready falls next cycle. Selection sequence is 01,01,00,00,00,00,00,00. Done pulses exactly 8 cycles after acceptance. Product=0x0000000F.
2. A=0xFFFF, B=0xFFFF. Required: every Selection=11, Product=0xFFFE0001, Done width 1 cycle.
3. Zero cases: A=0, B=0x1234 and then A=0xABCD, B=0. Required: Product=0 both times. The held Product from the previous test must be overwritten only at the Done edge.
4. Start held high continuously with A=7, B=9, then A=100, B=200. Required: accepts 10 cycles apart, Products 63 then 20000. Start pulses during RUN/DONE with other operands do not alter the results.
5. Reset asserted 4 edges into RUN, together with Start=1. Required: next cycle Ready=1, Busy=0, Product=0, Done=0, no Done pulse afterwards. A fresh Start with A=12, B=12 gives 144 with normal latency.
6. Randomized 1000 operand pairs against a reference A*B model. Required: exact match, and latency always 8.
